// File: rtl/fano_ch_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// fano_ch_dispatcher_pkg
// Shared definitions for the Fano decoder wrapper front end.
//   disp_state_t : dispatcher FSM states
//   log2()       : ceiling log2, used for select and counter widths
// ---------------------------------------------------------------------------
package fano_ch_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_XFER  = 2'd2
  } disp_state_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fano_ch_dispatcher_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first set request at or
// after ptr_i, searching upward with wrap.
//   req_i   [N_CHS]  request vector
//   ptr_i   [CH_W]   search start index
//   grant_o [CH_W]   granted index (0 when nothing requested)
//   any_o            at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
  import fano_ch_dispatcher_pkg::*;
#(
  parameter  int N_CHS = 4,
  localparam int CH_W  = log2(N_CHS)
) (
  input  logic [N_CHS-1:0] req_i,
  input  logic [CH_W-1:0]  ptr_i,
  output logic [CH_W-1:0]  grant_o,
  output logic             any_o
);

  logic [CH_W-1:0] idx;

  // Scan offsets from the farthest to the nearest so the lowest offset from
  // ptr_i overwrites any earlier hit. N_CHS is a power of 2, so the CH_W-bit
  // add wraps around the channel ring by itself.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = N_CHS - 1; k >= 0; k--) begin
      idx = ptr_i + k[CH_W-1:0];
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fano_ch_dispatcher.sv
// ---------------------------------------------------------------------------
// fano_ch_dispatcher
// Hands whole fixed-length frames to N_CHS Fano decoder channels in
// round-robin order, only to channels reporting idle. Owns the demux select
// and produces per-channel valid/SOF/EOF strobes registered on the same edge
// the demux registers its data, so both appear together one cycle later.
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_valid, i_sof   input beat valid / first beat of frame
//   o_ready          beat accepted when i_valid && o_ready
//   i_ch_ready       per-channel idle indication
//   o_mux_s          demux select (stable from grant through EOF)
//   o_ch_valid/sof/eof  one-hot strobes on bit o_mux_s
//   o_busy           frame in progress
//   o_err            one-cycle pulse per protocol-violating beat
// ---------------------------------------------------------------------------
module fano_ch_dispatcher
  import fano_ch_dispatcher_pkg::*;
#(
  parameter  int N_CHS     = 4,
  parameter  int FRAME_LEN = 1024,
  localparam int CH_W      = log2(N_CHS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_sof,
  output logic             o_ready,
  input  logic [N_CHS-1:0] i_ch_ready,
  output logic [CH_W-1:0]  o_mux_s,
  output logic [N_CHS-1:0] o_ch_valid,
  output logic [N_CHS-1:0] o_ch_sof,
  output logic [N_CHS-1:0] o_ch_eof,
  output logic             o_busy,
  output logic             o_err
);

  localparam int              CNT_W = log2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN);

  disp_state_t      state_q, state_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]  mux_s_q, mux_s_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N_CHS-1:0] valid_q, valid_d;
  logic [N_CHS-1:0] sof_q, sof_d;
  logic [N_CHS-1:0] eof_q, eof_d;
  logic             busy_q, err_q, err_d;
  logic             fwd, fwd_sof, fwd_eof;
  logic [CH_W-1:0]  arb_grant;
  logic             arb_any;
  logic [N_CHS-1:0] sel_oh;

  rr_arbiter #(.N_CHS(N_CHS)) u_arb (
    .req_i   (i_ch_ready),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Strobes only ever land on the committed channel.
  for (genvar gi = 0; gi < N_CHS; gi++) begin : g_strobe
    assign sel_oh[gi]  = (mux_s_q == CH_W'(gi));
    assign valid_d[gi] = fwd     && sel_oh[gi];
    assign sof_d[gi]   = fwd_sof && sel_oh[gi];
    assign eof_d[gi]   = fwd_eof && sel_oh[gi];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    mux_s_d  = mux_s_q;
    count_d  = count_q;
    fwd      = 1'b0;
    fwd_sof  = 1'b0;
    fwd_eof  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The select only moves here, where o_ready is low, so it is
        // stable at every edge that accepts a beat.
        if (arb_any) begin
          mux_s_d = arb_grant;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_valid) begin
          if (i_sof) begin
            fwd     = 1'b1;
            fwd_sof = 1'b1;
            count_d = CNT_W'(1);
            if (FRAME_LEN == 1) begin
              fwd_eof  = 1'b1;
              rr_ptr_d = mux_s_q + CH_W'(1);
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_XFER;
            end
          end else begin
            // Beat before any SOF: swallowed, flagged.
            err_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (i_valid) begin
          fwd     = 1'b1;
          err_d   = i_sof;  // length is fixed; a stray SOF is just data
          count_d = count_q + CNT_W'(1);
          if (count_d == LAST) begin
            fwd_eof  = 1'b1;
            rr_ptr_d = mux_s_q + CH_W'(1);
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      mux_s_q  <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      sof_q    <= '0;
      eof_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      mux_s_q  <= mux_s_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      busy_q   <= (state_d != ST_IDLE);
      err_q    <= err_d;
    end
  end

  assign o_ready    = (state_q != ST_IDLE);
  assign o_mux_s    = mux_s_q;
  assign o_ch_valid = valid_q;
  assign o_ch_sof   = sof_q;
  assign o_ch_eof   = eof_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_fano_ch_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_fano_ch_dispatcher
// Directed bench: one instance with FRAME_LEN=8, one with FRAME_LEN=1 fed
// by a model of the external demux for the alignment scenario.
// ---------------------------------------------------------------------------
module tb_fano_ch_dispatcher;

  logic       clk, rst;
  // FRAME_LEN = 8 instance
  logic       valid, sof, ready, busy, err;
  logic [3:0] ch_ready, ch_valid, ch_sof, ch_eof;
  logic [1:0] mux_s;
  // FRAME_LEN = 1 instance
  logic        valid1, sof1, ready1, busy1, err1;
  logic [3:0]  ch_ready1, ch_valid1, ch_sof1, ch_eof1;
  logic [1:0]  mux_s1;
  logic [31:0] data1;
  logic [31:0] demux_q [4];

  int checks = 0;
  int errors = 0;

  fano_ch_dispatcher #(.N_CHS(4), .FRAME_LEN(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .o_ready(ready),
    .i_ch_ready(ch_ready), .o_mux_s(mux_s), .o_ch_valid(ch_valid),
    .o_ch_sof(ch_sof), .o_ch_eof(ch_eof), .o_busy(busy), .o_err(err)
  );

  fano_ch_dispatcher #(.N_CHS(4), .FRAME_LEN(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .i_sof(sof1), .o_ready(ready1),
    .i_ch_ready(ch_ready1), .o_mux_s(mux_s1), .o_ch_valid(ch_valid1),
    .o_ch_sof(ch_sof1), .o_ch_eof(ch_eof1), .o_busy(busy1), .o_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External demux: registers the word into the selected slice on accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) demux_q[i] <= '0;
    end else if (valid1 && ready1) begin
      demux_q[mux_s1] <= data1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Optionally waits for the grant edge, then sends 8 beats. stray >= 0 puts
  // an extra SOF on that beat index.
  task automatic send_frame(input int exp_ch, input int stray, input bit do_grant);
    logic [3:0] oh;
    logic [3:0] exp_s, exp_e;
    oh = 4'b0001 << exp_ch;
    if (do_grant) begin
      cyc();
      checks++;
      if (ready !== 1'b1 || mux_s !== 2'(exp_ch) || busy !== 1'b1) begin
        errors++;
        $display("FAIL grant: ready=%b mux_s=%0d busy=%b, want ready=1 mux_s=%0d busy=1",
                 ready, mux_s, busy, exp_ch);
      end
    end
    for (int b = 0; b < 8; b++) begin
      valid = 1'b1;
      sof   = (b == 0) || (b == stray);
      cyc();
      valid = 1'b0;
      sof   = 1'b0;
      exp_s = (b == 0) ? oh : 4'b0000;
      exp_e = (b == 7) ? oh : 4'b0000;
      checks++;
      if (ch_valid !== oh || ch_sof !== exp_s || ch_eof !== exp_e) begin
        errors++;
        $display("FAIL beat ch=%0d b=%0d: valid=%b sof=%b eof=%b, want %b %b %b",
                 exp_ch, b, ch_valid, ch_sof, ch_eof, oh, exp_s, exp_e);
      end
      checks++;
      if (err !== (b == stray) || mux_s !== 2'(exp_ch)) begin
        errors++;
        $display("FAIL beat_err ch=%0d b=%0d: err=%b mux_s=%0d, want err=%b mux_s=%0d",
                 exp_ch, b, err, mux_s, (b == stray), exp_ch);
      end
    end
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bubble ch=%0d: ready=%b busy=%b, want 0 0", exp_ch, ready, busy);
    end
    $display("frame ch=%0d stray=%0d done", exp_ch, stray);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || mux_s !== 2'd0 || err !== 1'b0 ||
        ch_valid !== 4'b0 || ch_sof !== 4'b0 || ch_eof !== 4'b0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b mux_s=%0d err=%b v=%b s=%b e=%b, want all 0",
               ready, busy, mux_s, err, ch_valid, ch_sof, ch_eof);
    end
    $display("reset state checked");
  endtask

  task automatic test_round_robin();
    do_reset();
    ch_ready = 4'b1111;
    for (int f = 0; f < 4; f++) send_frame(f, -1, 1'b1);
  endtask

  task automatic test_skip_busy();
    do_reset();
    ch_ready = 4'b1010;
    send_frame(1, -1, 1'b1);
    send_frame(3, -1, 1'b1);
    send_frame(1, -1, 1'b1);
  endtask

  task automatic test_no_ready();
    do_reset();
    ch_ready = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_ready cyc=%0d: ready=%b busy=%b, want 0 0", i, ready, busy);
      end
    end
    $display("no_ready idle 20 cycles");
    ch_ready = 4'b0100;
    send_frame(2, -1, 1'b1);
  endtask

  task automatic test_errors();
    do_reset();
    ch_ready = 4'b1111;
    cyc();
    checks++;
    if (ready !== 1'b1 || mux_s !== 2'd0) begin
      errors++;
      $display("FAIL err_grant: ready=%b mux_s=%0d, want 1 0", ready, mux_s);
    end
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      sof   = 1'b0;
      cyc();
      valid = 1'b0;
      checks++;
      if (err !== 1'b1 || ch_valid !== 4'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL no_sof_beat %0d: err=%b valid=%b ready=%b, want 1 0000 1",
                 i, err, ch_valid, ready);
      end
      $display("discarded beat %0d", i);
    end
    send_frame(0, 4, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_ready = 4'b0100;
    cyc();
    checks++;
    if (mux_s !== 2'd2) begin
      errors++;
      $display("FAIL mid_grant: mux_s=%0d, want 2", mux_s);
    end
    for (int b = 0; b < 3; b++) begin
      valid = 1'b1;
      sof   = (b == 0);
      cyc();
    end
    checks++;
    if (ch_valid !== 4'b0100) begin
      errors++;
      $display("FAIL mid_beat3: valid=%b, want 0100", ch_valid);
    end
    // Beat 4 presented, reset hits mid-cycle before it is taken.
    sof = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ch_valid !== 4'b0 || ch_sof !== 4'b0 || ch_eof !== 4'b0 || mux_s !== 2'd0 ||
        ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b s=%b e=%b mux_s=%0d ready=%b busy=%b err=%b, want all 0",
               ch_valid, ch_sof, ch_eof, mux_s, ready, busy, err);
    end
    valid = 1'b0;
    cyc();
    checks++;
    if (ch_eof !== 4'b0) begin
      errors++;
      $display("FAIL reset_no_eof: eof=%b, want 0000", ch_eof);
    end
    rst      = 1'b0;
    ch_ready = 4'b1111;
    $display("reset mid-frame applied");
    send_frame(0, -1, 1'b1);
  endtask

  task automatic test_align();
    int         exp_ch1;
    bit         acc;
    logic [31:0] exp_word;
    logic [3:0] oh;
    ch_ready1 = 4'b1111;
    do_reset();
    exp_ch1 = 0;
    for (int i = 0; i < 60; i++) begin
      valid1 = 1'($urandom_range(1));
      sof1   = 1'b1;
      data1  = $urandom;
      acc    = valid1 && ready1;
      exp_word = data1;
      if (ready1) begin
        checks++;
        if (mux_s1 !== 2'(exp_ch1)) begin
          errors++;
          $display("FAIL align_sel i=%0d: mux_s=%0d, want %0d", i, mux_s1, exp_ch1);
        end
      end
      cyc();
      if (acc) begin
        oh = 4'b0001 << exp_ch1;
        checks++;
        if (ch_valid1 !== oh || ch_sof1 !== oh || ch_eof1 !== oh ||
            demux_q[exp_ch1] !== exp_word || ready1 !== 1'b0 || err1 !== 1'b0) begin
          errors++;
          $display("FAIL align i=%0d: v=%b s=%b e=%b data=%h ready=%b err=%b, want %b %b %b %h 0 0",
                   i, ch_valid1, ch_sof1, ch_eof1, demux_q[exp_ch1], ready1, err1,
                   oh, oh, oh, exp_word);
        end
        $display("single-beat frame ch=%0d data=%h", exp_ch1, exp_word);
        exp_ch1 = (exp_ch1 + 1) % 4;
      end else begin
        checks++;
        if (ch_valid1 !== 4'b0 || ch_eof1 !== 4'b0) begin
          errors++;
          $display("FAIL align_idle i=%0d: v=%b e=%b, want 0000 0000", i, ch_valid1, ch_eof1);
        end
      end
    end
    valid1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0; sof = 1'b0; ch_ready = 4'b0;
    valid1 = 1'b0; sof1 = 1'b0; ch_ready1 = 4'b0; data1 = '0;
    test_reset();
    test_round_robin();
    test_skip_busy();
    test_no_ready();
    test_errors();
    test_reset_mid();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
